change_dispenser: RTL

//  Downstream of the vending FSM. Takes the BCD change amount it produces (0x00..0x99) and pays
//  it out one coin at a time through a coin hopper using a req/ack handshake.

---
 rtl/change_dispenser_if.sv | 30 +++
 rtl/change_dispenser.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Bundle between the vending FSM / coin hopper side and the change dispenser.
// slave is the dispenser view; master is the upstream + hopper view.
interface change_dispenser_if #(
    parameter int CNT_W = 5
);
    logic             res_valid;
    logic [7:0]       res_bcd;
    logic             refill;
    logic             coin_ack;
    logic             busy;
    logic             coin_req;
    logic [4:0]       coin_type;
    logic [CNT_W-1:0] coin_cnt;
    logic [7:0]       remain_bcd;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output res_valid, res_bcd, refill, coin_ack,
        input  busy, coin_req, coin_type, coin_cnt,
        input  remain_bcd, done, err, err_code
    );

    modport slave (
        input  res_valid, res_bcd, refill, coin_ack,
        output busy, coin_req, coin_type, coin_cnt,
        output remain_bcd, done, err, err_code
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays a BCD change amount coin by coin through a req/ack hopper,
// choosing greedily from 50 down to 1 while tracking per-coin stock.
module change_dispenser #(
    parameter int CNT_W       = 5,
    parameter int INIT_STOCK  = 19,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_SEL  = 3'd2;
    localparam logic [2:0] S_DISP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [CNT_W-1:0] STOCK_INIT = CNT_W'(INIT_STOCK);
    localparam logic [7:0]       TMO_MAX    = 8'(ACK_TIMEOUT);

    localparam logic [1:0] E_BCD   = 2'd1;
    localparam logic [1:0] E_SHORT = 2'd2;
    localparam logic [1:0] E_TMO   = 2'd3;

    // Index 0..4 maps to coins 1,5,10,20,50 and to one-hot bit position.
    function automatic logic [6:0] denom(input logic [2:0] idx);
        logic [6:0] v;
        case (idx)
            3'd0:    v = 7'd1;
            3'd1:    v = 7'd5;
            3'd2:    v = 7'd10;
            3'd3:    v = 7'd20;
            default: v = 7'd50;
        endcase
        return v;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [6:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] stk_q [5];
    logic [CNT_W-1:0] stk_d [5];

    logic [3:0] tens_in, ones_in;
    logic [2:0] pick_idx;
    logic       pick_ok;
    logic [6:0] bcd_r;
    logic [3:0] bcd_t;
    logic [7:0] rem_bcd;

    assign tens_in = bcd_q[7:4];
    assign ones_in = bcd_q[3:0];

    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (!pick_ok && denom(3'(i)) <= rem_q && stk_q[i] != '0) begin
                pick_ok  = 1'b1;
                pick_idx = 3'(i);
            end
        end
    end

    // Binary to BCD by subtracting 80/40/20/10; remaining never exceeds 99.
    always_comb begin
        bcd_r = rem_q;
        bcd_t = 4'd0;
        if (bcd_r >= 7'd80) begin
            bcd_t[3] = 1'b1;
            bcd_r    = bcd_r - 7'd80;
        end
        if (bcd_r >= 7'd40) begin
            bcd_t[2] = 1'b1;
            bcd_r    = bcd_r - 7'd40;
        end
        if (bcd_r >= 7'd20) begin
            bcd_t[1] = 1'b1;
            bcd_r    = bcd_r - 7'd20;
        end
        if (bcd_r >= 7'd10) begin
            bcd_t[0] = 1'b1;
            bcd_r    = bcd_r - 7'd10;
        end
        rem_bcd = {bcd_t, bcd_r[3:0]};
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        code_d  = code_q;
        stk_d   = stk_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.refill) begin
                    for (int i = 0; i < 5; i++) stk_d[i] = STOCK_INIT;
                end
                if (bus.res_valid) begin
                    bcd_d   = bus.res_bcd;
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (tens_in > 4'd9 || ones_in > 4'd9) begin
                    code_d  = E_BCD;
                    state_d = S_ERR;
                end else begin
                    rem_d = {tens_in, 3'b000}
                          + {2'b00, tens_in, 1'b0}
                          + {3'b000, ones_in};
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (rem_q == 7'd0) begin
                    state_d = S_DONE;
                end else if (pick_ok) begin
                    idx_d   = pick_idx;
                    tmo_d   = 8'd0;
                    state_d = S_DISP;
                end else begin
                    code_d  = E_SHORT;
                    state_d = S_ERR;
                end
            end
            S_DISP: begin
                if (bus.coin_ack) begin
                    rem_d        = rem_q - denom(idx_q);
                    stk_d[idx_q] = stk_q[idx_q] - 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    state_d      = S_SEL;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TMO_MAX) begin
                        code_d  = E_TMO;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            code_q  <= '0;
            for (int i = 0; i < 5; i++) stk_q[i] <= STOCK_INIT;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            for (int i = 0; i < 5; i++) stk_q[i] <= stk_d[i];
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.coin_req   = (state_q == S_DISP);
    assign bus.coin_type  = bus.coin_req ? (5'b00001 << idx_q) : 5'b00000;
    assign bus.coin_cnt   = cnt_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.err_code   = bus.err ? code_q : 2'd0;
    assign bus.remain_bcd = bus.err ? rem_bcd : 8'h00;

endmodule
